// File: rtl/neurosync_pkg.sv
// Shared state codes, opcode constants and default timing for the NeuroSync
// game controller and its timers.
package neurosync_pkg;

  localparam int T_JOGADA_DEF = 250000000;
  localparam int T_MEDIDA_DEF = 5000000;

  localparam logic [1:0] OP_BOTOES    = 2'b00;
  localparam logic [1:0] OP_DISTANCIA = 2'b01;

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARA       = 4'h1,
    ESCOLHE_MODO  = 4'h2,
    REGISTRA      = 4'h3,
    CARREGA       = 4'h4,
    ESPERA_JOGADA = 4'h5,
    MEDE          = 4'h6,
    ESPERA_MEDIDA = 4'h7,
    AVALIA        = 4'h8,
    PROXIMA       = 4'h9,
    GANHOU        = 4'hA,
    PERDEU        = 4'hB
  } state_t;

endpackage

// File: rtl/neurosync_timer.sv
// Up-counter that raises fim at count M-1 and then holds there, so a long
// wait can never wrap back to zero.
module neurosync_timer #(
  parameter int M = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic fim
);

  localparam int W = (M > 1) ? $clog2(M) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != W'(M - 1))) begin
      count <= count + 1'b1;
    end
  end

  assign fim = (count == W'(M - 1));

endmodule

// File: rtl/neurosync_controller_dual_uc.sv
// Game controller: mode selection, then up to eight questions answered either
// by buttons (with timeout) or by a timed distance measurement.
module neurosync_controller_dual_uc
  import neurosync_pkg::*;
#(
  parameter int T_JOGADA = T_JOGADA_DEF,
  parameter int T_MEDIDA = T_MEDIDA_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       confirma,
  input  logic       pronto_play,
  input  logic       acertou_play,
  input  logic       acertou_faixa,
  input  logic [1:0] opcode,
  input  logic       is_ultima_pergunta,
  output logic       zera,
  output logic       zera_prep_jogo,
  output logic       registra_modo,
  output logic       set_pos,
  output logic       conta_pergunta,
  output logic       jogando,
  output logic       medir,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       timeout,
  output logic [3:0] acertos,
  output logic [3:0] db_estado
);

  state_t     state, state_next;
  logic       jogar_prev, confirma_prev;
  logic       jogar_edge, confirma_edge;
  logic       result;
  logic [3:0] acertos_q;
  logic       timeout_q;
  logic       fim_jog, fim_med;

  assign jogar_edge    = jogar & ~jogar_prev;
  assign confirma_edge = confirma & ~confirma_prev;

  neurosync_timer #(.M(T_JOGADA)) u_timer_jogada (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == CARREGA),
    .enable (state == ESPERA_JOGADA),
    .fim    (fim_jog)
  );

  neurosync_timer #(.M(T_MEDIDA)) u_timer_medida (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == MEDE),
    .enable (state == ESPERA_MEDIDA),
    .fim    (fim_med)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INICIAL;
    end else begin
      state <= state_next;
    end
  end

  // pronto_play qualifies acertou_play: the flag is only meaningful in the
  // cycle pronto_play is high, and an answer beats a simultaneous timeout.
  always_comb begin
    state_next = state;
    case (state)
      INICIAL:       if (jogar_edge) state_next = PREPARA;
      PREPARA:       state_next = ESCOLHE_MODO;
      ESCOLHE_MODO:  if (confirma_edge) state_next = REGISTRA;
      REGISTRA:      state_next = CARREGA;
      CARREGA: begin
        case (opcode)
          OP_BOTOES:    state_next = ESPERA_JOGADA;
          OP_DISTANCIA: state_next = MEDE;
          default:      state_next = is_ultima_pergunta ? GANHOU : PROXIMA;
        endcase
      end
      ESPERA_JOGADA: begin
        if (pronto_play)  state_next = AVALIA;
        else if (fim_jog) state_next = PERDEU;
      end
      MEDE:          state_next = ESPERA_MEDIDA;
      ESPERA_MEDIDA: if (fim_med) state_next = AVALIA;
      AVALIA: begin
        if (!result)                 state_next = PERDEU;
        else if (is_ultima_pergunta) state_next = GANHOU;
        else                         state_next = PROXIMA;
      end
      PROXIMA:       state_next = CARREGA;
      GANHOU,
      PERDEU:        if (jogar_edge) state_next = PREPARA;
      default:       state_next = INICIAL;
    endcase
  end

  // Score and timeout are cleared on the way into PREPARA so that PREPARA
  // itself already shows a fresh game.
  always_ff @(posedge clock) begin
    if (reset) begin
      jogar_prev    <= 1'b1;
      confirma_prev <= 1'b1;
      result        <= 1'b0;
      acertos_q     <= 4'd0;
      timeout_q     <= 1'b0;
    end else begin
      jogar_prev    <= jogar;
      confirma_prev <= confirma;
      if (state == ESPERA_JOGADA && pronto_play) begin
        result <= acertou_play;
      end else if (state == ESPERA_MEDIDA && fim_med) begin
        result <= acertou_faixa;
      end
      if (state_next == PREPARA || state == PREPARA) begin
        acertos_q <= 4'd0;
        timeout_q <= 1'b0;
      end else begin
        if (state == ESPERA_JOGADA && !pronto_play && fim_jog) begin
          timeout_q <= 1'b1;
        end
        if (state == AVALIA && result && acertos_q != 4'd8) begin
          acertos_q <= acertos_q + 4'd1;
        end
      end
    end
  end

  always_comb begin
    zera           = 1'b0;
    zera_prep_jogo = 1'b0;
    registra_modo  = 1'b0;
    set_pos        = 1'b0;
    conta_pergunta = 1'b0;
    jogando        = 1'b0;
    medir          = 1'b0;
    pronto         = 1'b0;
    ganhou         = 1'b0;
    perdeu         = 1'b0;
    case (state)
      PREPARA: begin
        zera           = 1'b1;
        zera_prep_jogo = 1'b1;
      end
      REGISTRA:      registra_modo = 1'b1;
      CARREGA: begin
        set_pos = 1'b1;
        jogando = 1'b1;
      end
      ESPERA_JOGADA: jogando = 1'b1;
      MEDE: begin
        medir   = 1'b1;
        jogando = 1'b1;
      end
      ESPERA_MEDIDA: jogando = 1'b1;
      AVALIA:        jogando = 1'b1;
      PROXIMA: begin
        conta_pergunta = 1'b1;
        jogando        = 1'b1;
      end
      GANHOU: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      PERDEU: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      default: ;
    endcase
  end

  assign acertos   = acertos_q;
  assign timeout   = timeout_q;
  assign db_estado = state;

endmodule

// File: tb/tb_neurosync_controller_dual_uc.sv
// Bench for the NeuroSync controller: directed and random games checked
// against a question-by-question outcome model.
module tb_neurosync_controller_dual_uc;

  localparam int TJ = 20;
  localparam int TM = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       jogar = 1'b0;
  logic       confirma = 1'b0;
  logic       pronto_play = 1'b0;
  logic       acertou_play = 1'b0;
  logic       acertou_faixa = 1'b0;
  logic [1:0] opcode = 2'b00;
  logic       is_ultima_pergunta = 1'b0;
  logic       zera, zera_prep_jogo, registra_modo, set_pos, conta_pergunta;
  logic       jogando, medir, pronto, ganhou, perdeu, timeout;
  logic [3:0] acertos, db_estado;

  int n_tests = 0;
  int n_fail  = 0;
  int conta_cnt = 0;
  int medir_cnt = 0;

  int op_a[8];
  int del_a[8];
  bit ok_a[8];

  neurosync_controller_dual_uc #(.T_JOGADA(TJ), .T_MEDIDA(TM)) dut (
    .clock              (clock),
    .reset              (reset),
    .jogar              (jogar),
    .confirma           (confirma),
    .pronto_play        (pronto_play),
    .acertou_play       (acertou_play),
    .acertou_faixa      (acertou_faixa),
    .opcode             (opcode),
    .is_ultima_pergunta (is_ultima_pergunta),
    .zera               (zera),
    .zera_prep_jogo     (zera_prep_jogo),
    .registra_modo      (registra_modo),
    .set_pos            (set_pos),
    .conta_pergunta     (conta_pergunta),
    .jogando            (jogando),
    .medir              (medir),
    .pronto             (pronto),
    .ganhou             (ganhou),
    .perdeu             (perdeu),
    .timeout            (timeout),
    .acertos            (acertos),
    .db_estado          (db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (conta_pergunta === 1'b1) conta_cnt++;
    if (medir === 1'b1) medir_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_q(input int q);
    opcode             = 2'(op_a[q]);
    is_ultima_pergunta = (q == 7);
    acertou_faixa      = ok_a[q];
  endtask

  // Outcome of a whole game from the question list alone.
  function automatic void model_game(output int acc, output bit win, output bit to,
                                     output int conta, output int med);
    bit done;
    acc = 0; win = 0; to = 0; conta = 0; med = 0; done = 0;
    for (int q = 0; q < 8; q++) begin
      if (!done) begin
        if (op_a[q] >= 2) begin
          if (q == 7) win = 1; else conta++;
        end else if (op_a[q] == 0 && del_a[q] > TJ) begin
          to = 1; done = 1;
        end else begin
          if (op_a[q] == 1) med++;
          if (!ok_a[q]) done = 1;
          else begin
            acc = (acc < 8) ? acc + 1 : 8;
            if (q == 7) win = 1; else conta++;
          end
        end
      end
    end
  endfunction

  task automatic start_game(input string name);
    jogar = 1'b0; confirma = 1'b0;
    step();
    jogar = 1'b1;
    step();
    chk({name, "_prepara_state"}, 32'(db_estado), 32'd1);
    chk({name, "_prepara_zera"}, 32'({zera, zera_prep_jogo}), 32'd3);
    chk({name, "_prepara_acertos"}, 32'(acertos), 32'd0);
    chk({name, "_prepara_timeout"}, 32'(timeout), 32'd0);
    jogar = 1'b0;
    step();
    chk({name, "_escolhe"}, 32'({db_estado, jogando}), 32'({4'd2, 1'b0}));
    step();
    chk({name, "_escolhe_hold"}, 32'(db_estado), 32'd2);
    confirma = 1'b1;
    step();
    chk({name, "_registra"}, 32'({db_estado, registra_modo}), 32'({4'd3, 1'b1}));
    confirma = 1'b0;
    set_q(0);
    step();
  endtask

  task automatic play_game(input string name);
    int e_acc, e_conta, e_med, conta0, med0, acc, q;
    bit e_win, e_to, done;
    model_game(e_acc, e_win, e_to, e_conta, e_med);
    conta0 = conta_cnt;
    med0 = medir_cnt;
    start_game(name);
    acc = 0; q = 0; done = 0;
    while (!done) begin
      chk($sformatf("%s_q%0d_carrega", name, q), 32'({db_estado, set_pos, jogando}),
          32'({4'd4, 2'b11}));
      if (op_a[q] >= 2) begin
        step();
        if (q == 7) done = 1;
        else begin
          chk($sformatf("%s_q%0d_skip", name, q), 32'(db_estado), 32'd9);
          q++;
          set_q(q);
          step();
        end
      end else if (op_a[q] == 0 && del_a[q] > TJ) begin
        repeat (TJ) begin
          jogar = 1'($urandom_range(0, 1)); confirma = 1'($urandom_range(0, 1));
          step();
        end
        chk($sformatf("%s_q%0d_wait_last", name, q), 32'(db_estado), 32'd5);
        jogar = 1'b0; confirma = 1'b0;
        step();
        chk($sformatf("%s_q%0d_timeout_state", name, q), 32'(db_estado), 32'd11);
        done = 1;
      end else begin
        if (op_a[q] == 0) begin
          repeat (del_a[q]) begin
            jogar = 1'($urandom_range(0, 1)); confirma = 1'($urandom_range(0, 1));
            step();
          end
          jogar = 1'b0; confirma = 1'b0;
          pronto_play = 1'b1; acertou_play = ok_a[q];
          step();
          pronto_play = 1'b0; acertou_play = 1'b0;
        end else begin
          step();
          chk($sformatf("%s_q%0d_mede", name, q), 32'({db_estado, medir}), 32'({4'd6, 1'b1}));
          step();
          chk($sformatf("%s_q%0d_espera_med", name, q), 32'({db_estado, medir}),
              32'({4'd7, 1'b0}));
          repeat (TM) step();
        end
        chk($sformatf("%s_q%0d_avalia", name, q), 32'({db_estado, jogando}),
            32'({4'd8, 1'b1}));
        chk($sformatf("%s_q%0d_avalia_to", name, q), 32'(timeout), 32'd0);
        step();
        if (!ok_a[q]) done = 1;
        else begin
          acc++;
          chk($sformatf("%s_q%0d_acertos", name, q), 32'(acertos), 32'(acc));
          if (q == 7) done = 1;
          else begin
            chk($sformatf("%s_q%0d_proxima", name, q), 32'({db_estado, conta_pergunta}),
                32'({4'd9, 1'b1}));
            q++;
            set_q(q);
            step();
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      chk({name, "_end_state"}, 32'(db_estado), e_win ? 32'd10 : 32'd11);
      chk({name, "_end_flags"}, 32'({pronto, ganhou, perdeu, timeout}),
          32'({1'b1, e_win, ~e_win, e_to}));
      chk({name, "_end_acertos"}, 32'(acertos), 32'(e_acc));
      step();
    end
    chk({name, "_conta_pulses"}, 32'(conta_cnt - conta0), 32'(e_conta));
    chk({name, "_medir_cycles"}, 32'(medir_cnt - med0), 32'(e_med));
  endtask

  task automatic fill(input int op, input int del, input bit ok);
    for (int q = 0; q < 8; q++) begin
      op_a[q] = op; del_a[q] = del; ok_a[q] = ok;
    end
  endtask

  initial begin
    // Reset with start button held: no start until released and pressed again.
    jogar = 1'b1;
    repeat (3) step();
    chk("reset_outs", 32'({zera, zera_prep_jogo, registra_modo, set_pos, conta_pergunta,
        jogando, medir, pronto, ganhou, perdeu, timeout, acertos, db_estado}), 32'd0);
    reset = 1'b0;
    repeat (4) step();
    chk("held_jogar_no_start", 32'(db_estado), 32'd0);

    fill(0, 3, 1'b1);
    play_game("win");

    fill(0, 3, 1'b1);
    op_a[0] = 1; del_a[1] = TJ; ok_a[2] = 1'b0;
    play_game("dist_simul_wrong");

    fill(0, 3, 1'b1);
    del_a[0] = 2; del_a[1] = 30;
    play_game("timeout");

    fill(0, 5, 1'b1);
    op_a[0] = 2; op_a[2] = 1; op_a[3] = 3; op_a[6] = 1; op_a[7] = 2;
    play_game("reserved");

    for (int g = 0; g < 10; g++) begin
      for (int q = 0; q < 8; q++) begin
        int r;
        r = $urandom_range(0, 9);
        op_a[q]  = (r < 5) ? 0 : (r < 9) ? 1 : $urandom_range(2, 3);
        del_a[q] = $urandom_range(1, TJ + 2);
        ok_a[q]  = ($urandom_range(0, 7) != 0);
      end
      play_game($sformatf("rand%0d", g));
    end

    // Reset in the middle of a distance measurement.
    fill(1, 3, 1'b1);
    start_game("midreset");
    step();
    step();
    step();
    chk("midreset_in_espera_med", 32'(db_estado), 32'd7);
    reset = 1'b1; jogar = 1'b1;
    step();
    chk("midreset_outs", 32'({zera, zera_prep_jogo, registra_modo, set_pos, conta_pergunta,
        jogando, medir, pronto, ganhou, perdeu, timeout, acertos, db_estado}), 32'd0);
    reset = 1'b0;
    repeat (3) step();
    chk("midreset_held_jogar", 32'(db_estado), 32'd0);

    fill(0, 4, 1'b1);
    play_game("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neurosync_controller_dual_uc.md
NEUROSYNC_CONTROLLER_DUAL_UC -- requirements
Module: neurosync_controller_dual_uc

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clock and reset.
REQ-002 Parameter T_JOGADA SHALL default to 250000000 and set the answer timeout in clock cycles (5 s at 50 MHz).
REQ-003 Parameter T_MEDIDA SHALL default to 5000000 and set the wait in clock cycles from the medir pulse to sampling acertou_faixa.
REQ-004 Ports SHALL be, in this order:
 clock  in  1  system clock
 reset  in  1  synchronous active-high reset
 jogar  in  1  raw start button (level)
 confirma  in  1  raw confirm button (level)
 pronto_play  in  1  answer-complete pulse from datapath
 acertou_play  in  1  answer-correct flag, valid with pronto_play
 acertou_faixa  in  1  distance-in-range flag (level)
 opcode  in  2  current question type
 is_ultima_pergunta  in  1  question address is 7
 zera  out  1  clear mode register and question counter
 zera_prep_jogo  out  1  re-centre servo
 registra_modo  out  1  latch servo position as game mode
 set_pos  out  1  load the question's initial servo position
 conta_pergunta  out  1  advance question address
 jogando  out  1  game active (LEDs show question)
 medir  out  1  start one distance measurement
 pronto  out  1  game over
 ganhou  out  1  game won
 perdeu  out  1  game lost
 timeout  out  1  loss caused by answer timeout
 acertos  out  4  correct-answer count, 0..8
 db_estado  out  4  current state code

Function
REQ-005 The block SHALL generate rising-edge pulses of jogar and confirma internally; the previous-value registers SHALL reset to 1, so a button held through reset produces no edge.
REQ-006 Every output SHALL be a Moore output decoded from the state register or a dedicated register, and SHALL be glitch-free within a cycle.
REQ-007 The states and their codes SHALL be: INICIAL 0, PREPARA 1, ESCOLHE_MODO 2, REGISTRA 3, CARREGA 4, ESPERA_JOGADA 5, MEDE 6, ESPERA_MEDIDA 7, AVALIA 8, PROXIMA 9, GANHOU A, PERDEU B. db_estado SHALL equal the state code.
REQ-008 INICIAL SHALL go to PREPARA on a jogar edge; otherwise it SHALL hold.
REQ-009 PREPARA SHALL last one cycle, assert zera and zera_prep_jogo, clear acertos and timeout, and go to ESCOLHE_MODO.
REQ-010 ESCOLHE_MODO SHALL hold with jogando=0 until a confirma edge, then go to REGISTRA.
REQ-011 REGISTRA SHALL last one cycle, assert registra_modo, and go to CARREGA.
REQ-012 CARREGA SHALL last one cycle, assert set_pos and jogando, and branch on opcode:
 - 00: to ESPERA_JOGADA.
 - 01: to MEDE.
 - 10 or 11 (reserved): the question is skipped unscored, to GANHOU if is_ultima_pergunta, else to PROXIMA.
REQ-013 ESPERA_JOGADA SHALL assert jogando and run the timer from 0.
 - On pronto_play: latch acertou_play into the result register and go to AVALIA.
 - Else, when the timer reaches T_JOGADA-1: set timeout and go to PERDEU.
 - If pronto_play and expiry occur in the same cycle, pronto_play SHALL win.
REQ-014 MEDE SHALL last one cycle, assert medir and jogando, clear the timer, and go to ESPERA_MEDIDA.
REQ-015 ESPERA_MEDIDA SHALL assert jogando. When the timer reaches T_MEDIDA-1, it SHALL latch acertou_faixa into the result register and go to AVALIA.
REQ-016 AVALIA SHALL last one cycle with jogando=1.
 - Result 0: go to PERDEU.
 - Result 1: increment acertos, then go to GANHOU if is_ultima_pergunta, else to PROXIMA.
REQ-017 PROXIMA SHALL last one cycle, assert conta_pergunta and jogando, and go to CARREGA.
REQ-018 GANHOU SHALL assert pronto and ganhou. PERDEU SHALL assert pronto and perdeu. Both SHALL hold acertos and timeout, and go to PREPARA on a jogar edge.
REQ-019 Jogar and confirma edges SHALL be ignored in every state not named in REQ-008, REQ-010 and REQ-018.
REQ-020 acertos SHALL saturate at 8.
REQ-021 The timer SHALL be wide enough for max(T_JOGADA, T_MEDIDA) with no wrap-around, and SHALL be cleared on every entry to ESPERA_JOGADA and ESPERA_MEDIDA.

Reset
REQ-022 Reset SHALL take priority over all other inputs and act in any state, including mid-game.
REQ-023 On reset: state = INICIAL, timer = 0, result = 0, acertos = 0, timeout = 0, and every pulse and level output = 0.

Structure
REQ-024 The state codes, the opcode constants (OP_BOTOES=00, OP_DISTANCIA=01) and the T_JOGADA/T_MEDIDA defaults SHALL live in shared package neurosync_pkg.
REQ-025 The timer SHALL be one sub-module, neurosync_timer, with clear, enable, parameter M and output fim at M-1. It SHALL be instantiated twice (M=T_JOGADA, M=T_MEDIDA) or once with a selectable limit.
REQ-026 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-027 Benches SHALL use T_JOGADA=20 and T_MEDIDA=8.
REQ-028 The bench SHALL cover these directed scenarios:
 - Full win: reset; jogar; confirma; 8 questions with opcode=00, each pronto_play=1 with acertou_play=1 three cycles after CARREGA; is_ultima_pergunta=1 on question 8 -> ganhou=1, pronto=1, acertos=8, db_estado=A, exactly 7 conta_pergunta pulses.
 - Distance question: opcode=01, acertou_faixa=1 -> medir high exactly one cycle; AVALIA reached exactly 9 cycles after MEDE (1 cycle to ESPERA_MEDIDA + 8 cycles of wait); acertos increments by 1.
 - Timeout: opcode=00 and no pronto_play -> PERDEU entered 20 cycles after ESPERA_JOGADA entry; timeout=1, perdeu=1, acertos unchanged.
 - Simultaneous event: pronto_play with acertou_play=1 on timer count 19 -> AVALIA, timeout=0.
 - Wrong answer and restart: acertou_play=0 on question 3 -> perdeu=1, acertos=2; then a jogar edge -> PREPARA with zera=1 and zera_prep_jogo=1, acertos=0.
 - Reset and held button: reset asserted in ESPERA_MEDIDA -> next cycle INICIAL with all outputs 0; jogar held high through reset -> no start until it is released and pressed again.
